key_sched_ctrl: RTL and testbench

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/key_word_gen.sv | 22 ++
 rtl/key_sched_ctrl.sv | 171 +++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the key schedule: S-box, RotWord, SubWord, xtime,
// plus the controller state and word-generation mode types.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_FIN
    } ks_state_t;

    typedef enum logic [1:0] {
        MODE_XOR,
        MODE_ROT,
        MODE_SUB
    } word_mode_t;

    // Byte 0 of the S-box sits in the top byte of this table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_word_gen.sv
// Combinational generator for one expanded key word w[i] from w[i-1],
// w[i-NK], the current round constant and the position-dependent mode.
module key_word_gen
    import aes_pkg::*;
(
    input  logic [31:0] i_w_prev,
    input  logic [31:0] i_w_back,
    input  logic [7:0]  i_rcon,
    input  word_mode_t  i_mode,
    output logic [31:0] o_w_new
);

    always_comb begin
        o_w_new = i_w_back ^ i_w_prev;
        case (i_mode)
            MODE_ROT: o_w_new = i_w_back ^ sub_word(rot_word(i_w_prev)) ^ {i_rcon, 24'h0};
            MODE_SUB: o_w_new = i_w_back ^ sub_word(i_w_prev);
            default:  o_w_new = i_w_back ^ i_w_prev;
        endcase
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES key-expansion controller: expands an NK-word key one word per cycle and
// serves round keys combinationally. KEY_SCHED_ZEROIZE_EN adds storage wipe.
module key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NK*32-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             key_ready,
    input  logic [3:0]       rd_round,
    output logic [127:0]     rd_key,
    output logic             rd_valid
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    localparam int NW = 4 * (NR + 1);
    localparam int IW = 6;
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    ks_state_t   r_state;
    ks_state_t   w_state_next;
    logic        w_accept;
    logic [IW-1:0] r_i;
    logic [7:0]  r_rcon;
    logic [2:0]  r_mod;
    logic        r_key_ready;
    logic [31:0] r_w [0:NW-1];

    word_mode_t  w_mode;
    logic [31:0] w_new;
    logic [IW-1:0] w_idx_prev;
    logic [IW-1:0] w_idx_back;
    logic [IW-1:0] w_rd_base;

`ifdef KEY_SCHED_ZEROIZE_EN
    logic          r_zero_act;
    logic [IW-1:0] r_zero_idx;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = start;
`ifdef KEY_SCHED_ZEROIZE_EN
                w_accept = start && !r_zero_act;
`endif
                if (w_accept) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy         = 1'b1;
                w_state_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                busy = 1'b1;
                if (r_i == LAST) w_state_next = ST_FIN;
            end
            ST_FIN: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
`ifdef KEY_SCHED_ZEROIZE_EN
        // Zeroize overrides everything, including a simultaneous start.
        if (zeroize) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
        end
        if (r_zero_act) busy = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_rcon      <= 8'h01;
            r_mod       <= '0;
            r_key_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_key_ready <= 1'b0;
            if (r_state == ST_EXPAND && w_state_next == ST_FIN) r_key_ready <= 1'b1;
            if (r_state == ST_LOAD) begin
                r_i    <= IW'(NK);
                r_rcon <= 8'h01;
                r_mod  <= '0;
            end else if (r_state == ST_EXPAND) begin
                r_i   <= r_i + 1'b1;
                r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
                if (w_mode == MODE_ROT) r_rcon <= xtime(r_rcon);
            end
`ifdef KEY_SCHED_ZEROIZE_EN
            if (zeroize) r_key_ready <= 1'b0;
`endif
        end
    end

`ifdef KEY_SCHED_ZEROIZE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero_act <= 1'b0;
            r_zero_idx <= '0;
        end else if (zeroize) begin
            r_zero_act <= 1'b1;
            r_zero_idx <= '0;
        end else if (r_zero_act) begin
            r_zero_idx <= r_zero_idx + 1'b1;
            if (r_zero_idx == LAST) r_zero_act <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_mode = MODE_XOR;
        if (r_mod == 3'd0) w_mode = MODE_ROT;
        else if (NK == 8 && r_mod == 3'd4) w_mode = MODE_SUB;
    end

    assign w_idx_prev = r_i - 1'b1;
    assign w_idx_back = r_i - IW'(NK);

    key_word_gen u_word_gen (
        .i_w_prev (r_w[w_idx_prev]),
        .i_w_back (r_w[w_idx_back]),
        .i_rcon   (r_rcon),
        .i_mode   (w_mode),
        .o_w_new  (w_new)
    );

    // The key is captured on the accepting edge so key_in need only be valid
    // alongside start; storage deliberately carries no reset.
    always_ff @(posedge clk) begin
`ifdef KEY_SCHED_ZEROIZE_EN
        if (r_zero_act) begin
            r_w[r_zero_idx] <= '0;
        end else
`endif
        if (w_accept) begin
            for (int k = 0; k < NK; k++) begin
                r_w[k] <= key_in[NK*32-1-32*k -: 32];
            end
        end else if (r_state == ST_EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

    assign key_ready = r_key_ready;
    assign rd_valid  = r_key_ready && (rd_round <= 4'(NR));
    assign w_rd_base = rd_valid ? {rd_round, 2'b00} : '0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd
            assign rd_key[127-32*gi -: 32] = rd_valid ? r_w[w_rd_base + IW'(gi)] : 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl with AES-128/192/256 instances.
// Define KEY_SCHED_ZEROIZE_EN to also exercise the zeroize path.
module tb_key_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   start;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [3:0]   rd_round [3];
`ifdef KEY_SCHED_ZEROIZE_EN
    logic [2:0]   zz;
`endif

    wire busy4, done4, kr4, rv4;
    wire busy6, done6, kr6, rv6;
    wire busy8, done8, kr8, rv8;
    wire [127:0] rk4, rk6, rk8;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_sched_ctrl #(.NK(4), .NR(10)) dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .key_in(key4),
        .busy(busy4), .done(done4), .key_ready(kr4),
        .rd_round(rd_round[0]), .rd_key(rk4), .rd_valid(rv4)
`ifdef KEY_SCHED_ZEROIZE_EN
        , .zeroize(zz[0])
`endif
    );

    key_sched_ctrl #(.NK(6), .NR(12)) dut6 (
        .clk(clk), .rst(rst), .start(start[1]), .key_in(key6),
        .busy(busy6), .done(done6), .key_ready(kr6),
        .rd_round(rd_round[1]), .rd_key(rk6), .rd_valid(rv6)
`ifdef KEY_SCHED_ZEROIZE_EN
        , .zeroize(zz[1])
`endif
    );

    key_sched_ctrl #(.NK(8), .NR(14)) dut8 (
        .clk(clk), .rst(rst), .start(start[2]), .key_in(key8),
        .busy(busy8), .done(done8), .key_ready(kr8),
        .rd_round(rd_round[2]), .rd_key(rk8), .rd_valid(rv8)
`ifdef KEY_SCHED_ZEROIZE_EN
        , .zeroize(zz[2])
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic get_done(input int s);
        case (s) 0: return done4; 1: return done6; default: return done8; endcase
    endfunction
    function automatic logic get_busy(input int s);
        case (s) 0: return busy4; 1: return busy6; default: return busy8; endcase
    endfunction
    function automatic logic get_kr(input int s);
        case (s) 0: return kr4; 1: return kr6; default: return kr8; endcase
    endfunction
    function automatic logic get_rv(input int s);
        case (s) 0: return rv4; 1: return rv6; default: return rv8; endcase
    endfunction
    function automatic logic [127:0] get_rk(input int s);
        case (s) 0: return rk4; 1: return rk6; default: return rk8; endcase
    endfunction

    typedef struct {
        int           sel;
        logic [3:0]   rnd;
        logic [127:0] val;
        logic         vld;
    } exp_t;
    exp_t sb_q[$];

    task automatic push_exp(input int s, input int r, input logic [127:0] v, input logic vld);
        exp_t e;
        e.sel = s; e.rnd = 4'(r); e.val = v; e.vld = vld;
        sb_q.push_back(e);
    endtask

    task automatic drain_sb();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            rd_round[e.sel] = e.rnd;
            #1;
            check_eq($sformatf("dut%0d rd_key r%0d", e.sel, e.rnd), get_rk(e.sel), e.val);
            check_eq($sformatf("dut%0d rd_valid r%0d", e.sel, e.rnd), 128'(get_rv(e.sel)), 128'(e.vld));
        end
    endtask

    // Starts an expansion; the key input is inverted after acceptance to show it
    // is sampled only on the accepting edge.
    task automatic run_expand(input int s, input int exp_lat, input int restart_at, input int rst_at);
        int first;
        int n_done;
        logic [127:0] k4s;
        logic [191:0] k6s;
        logic [255:0] k8s;
        first  = -1;
        n_done = 0;
        k4s = key4; k6s = key6; k8s = key8;
        @(negedge clk);
        start[s] = 1'b1;
        @(posedge clk);
        #1;
        start[s] = 1'b0;
        for (int k = 1; k <= exp_lat + 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                case (s) 0: key4 = ~k4s; 1: key6 = ~k6s; default: key8 = ~k8s; endcase
                check_eq($sformatf("dut%0d busy in LOAD", s), 128'(get_busy(s)), 128'(1));
                check_eq($sformatf("dut%0d key_ready in LOAD", s), 128'(get_kr(s)), 128'(0));
            end
            if (get_done(s)) begin
                n_done++;
                if (first < 0) begin
                    first = k;
                    check_eq($sformatf("dut%0d key_ready at done", s), 128'(get_kr(s)), 128'(1));
                    check_eq($sformatf("dut%0d busy at done", s), 128'(get_busy(s)), 128'(0));
                end
            end
            start[s] = (restart_at > 0 && k == restart_at - 1);
            if (rst_at > 0 && k == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq($sformatf("dut%0d busy after rst", s), 128'(get_busy(s)), 128'(0));
                check_eq($sformatf("dut%0d key_ready after rst", s), 128'(get_kr(s)), 128'(0));
                rst = 1'b0;
            end
        end
        start[s] = 1'b0;
        if (rst_at > 0) begin
            check_eq($sformatf("dut%0d done count after rst", s), 128'(n_done), 128'(0));
        end else begin
            check_eq($sformatf("dut%0d done count", s), 128'(n_done), 128'(1));
            check_eq($sformatf("dut%0d latency", s), 128'(first), 128'(exp_lat));
        end
        key4 = k4s; key6 = k6s; key8 = k8s;
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        for (int r = 0; r < 3; r++) rd_round[r] = '0;
`ifdef KEY_SCHED_ZEROIZE_EN
        zz = '0;
`endif
        key4 = K128; key6 = K192; key8 = K256;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset busy", 128'(busy4), 128'(0));
        check_eq("reset done", 128'(done4), 128'(0));
        check_eq("reset key_ready", 128'(kr4), 128'(0));
        check_eq("reset rd_valid", 128'(rv4), 128'(0));
        check_eq("reset rd_key", rk4, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // AES-128 with out-of-range reads
        push_exp(0, 0,  K128, 1'b1);
        push_exp(0, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        push_exp(0, 2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b1);
        push_exp(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        push_exp(0, 11, 128'h0, 1'b0);
        push_exp(0, 15, 128'h0, 1'b0);
        run_expand(0, 41, 0, 0);
        drain_sb();

        // second start at cycle 10 is ignored
        push_exp(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        push_exp(0, 0,  K128, 1'b1);
        run_expand(0, 41, 10, 0);
        drain_sb();

        // reset at cycle 20 aborts, then a clean rerun
        run_expand(0, 41, 0, 20);
        push_exp(0, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        push_exp(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        run_expand(0, 41, 0, 0);
        drain_sb();

        // AES-192
        push_exp(1, 0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1);
        push_exp(1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b1);
        push_exp(1, 13, 128'h0, 1'b0);
        run_expand(1, 47, 0, 0);
        drain_sb();

        // AES-256
        push_exp(2, 1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b1);
        push_exp(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1);
        push_exp(2, 15, 128'h0, 1'b0);
        run_expand(2, 53, 0, 0);
        drain_sb();

`ifdef KEY_SCHED_ZEROIZE_EN
        begin
            int zlen;
            zlen = -1;
            @(negedge clk);
            zz[0] = 1'b1;
            @(posedge clk);
            #1;
            zz[0] = 1'b0;
            check_eq("zeroize key_ready", 128'(kr4), 128'(0));
            check_eq("zeroize busy", 128'(busy4), 128'(1));
            for (int k = 1; k <= 100; k++) begin
                @(posedge clk);
                #1;
                if (!busy4) begin
                    zlen = k;
                    break;
                end
            end
            check_eq("zeroize busy cycles", 128'(zlen), 128'(44));
            for (int r = 0; r <= 10; r++) push_exp(0, r, 128'h0, 1'b0);
            drain_sb();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
